// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and decode helper for the ALU issue controller.
// Holds ALU op codes, MIPS opcode/funct values, FSM states, decode bundle.
package alu_issue_pkg;

   localparam int REG_W = 32;
   localparam int NREG  = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_XNOR = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_SLTU = 3'b110;
   localparam logic [2:0] OP_SLL  = 3'b111;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;

   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_XNOR = 6'b100111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLTU = 6'b101011;
   localparam logic [5:0] FN_SLLV = 6'b000100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   typedef struct packed {
      logic       legal;
      logic       use_imm;
      logic [2:0] op;
      logic [4:0] dest;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t       d;
      logic       r;
      logic [5:0] fn;
      d  = '0;
      r  = (w[31:26] == OPC_RTYPE);
      fn = w[5:0];
      unique case (1'b1)
         r && fn == FN_AND:  d.op = OP_AND;
         r && fn == FN_OR:   d.op = OP_OR;
         r && fn == FN_XOR:  d.op = OP_XOR;
         r && fn == FN_XNOR: d.op = OP_XNOR;
         r && fn == FN_ADD:  d.op = OP_ADD;
         r && fn == FN_SUB:  d.op = OP_SUB;
         r && fn == FN_SLTU: d.op = OP_SLTU;
         r && fn == FN_SLLV: d.op = OP_SLL;
         w[31:26] == OPC_ADDI: begin
            d.op      = OP_ADD;
            d.use_imm = 1'b1;
         end
         default: ;
      endcase
      // Anything left at OP_AND without a match is unsupported.
      d.legal = (r && (fn == FN_AND || fn == FN_OR || fn == FN_XOR ||
                       fn == FN_XNOR || fn == FN_ADD || fn == FN_SUB ||
                       fn == FN_SLTU || fn == FN_SLLV)) ||
                (w[31:26] == OPC_ADDI);
      d.dest = !d.legal ? 5'd0 : (d.use_imm ? w[20:16] : w[15:11]);
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus external ALU bus for the issue controller.
// master: instruction source and ALU; slave: the issue controller.
interface alu_issue_ctrl_if;
   import alu_issue_pkg::*;

   logic             instr_valid;
   logic             instr_ready;
   logic [31:0]      instr;
   logic [2:0]       alu_op;
   logic [REG_W-1:0] alu_a;
   logic [REG_W-1:0] alu_b;
   logic [REG_W-1:0] alu_f;
   logic             alu_of;
   logic             alu_zf;

   modport master (
      output instr_valid, instr, alu_f, alu_of, alu_zf,
      input  instr_ready, alu_op, alu_a, alu_b
   );

   modport slave (
      input  instr_valid, instr, alu_f, alu_of, alu_zf,
      output instr_ready, alu_op, alu_a, alu_b
   );

endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// 32x32 register file, r0 hard-wired to zero, synchronous clear on rst.
// Ports: two async reads (a/b), async debug read, one sync write.
module reg_file_32x32
   import alu_issue_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       raddr_a,
   output logic [REG_W-1:0] rdata_a,
   input  logic [4:0]       raddr_b,
   output logic [REG_W-1:0] rdata_b,
   input  logic [4:0]       dbg_addr,
   output logic [REG_W-1:0] dbg_data,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [REG_W-1:0] wdata
);

   logic [REG_W-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a  = regs[raddr_a];
   assign rdata_b  = regs[raddr_b];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues MIPS-style words to an external ALU: accept, execute, write back.
// Ports: clk/rst, bus (handshake + ALU), done/result/flags/illegal, dbg read.
module alu_issue_ctrl
   import alu_issue_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   alu_issue_ctrl_if.slave      bus,
   output logic                 done,
   output logic [REG_W-1:0]     result,
   output logic                 of_flag,
   output logic                 zf_flag,
   output logic                 illegal,
   input  logic [4:0]           dbg_addr,
   output logic [REG_W-1:0]     dbg_data
);

   state_t           state, next;
   logic             ready, we;
   logic [31:0]      instr_q;
   logic [2:0]       op_q;
   logic [REG_W-1:0] a_q, b_q;
   logic [4:0]       dest_q;
   logic             legal_q;
   logic [REG_W-1:0] rs_data, rt_data, imm_ext;
   dec_t             dec;

   assign dec     = decode(instr_q);
   assign imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};

   reg_file_32x32 u_rf (
      .clk      (clk),
      .rst      (rst),
      .raddr_a  (instr_q[25:21]),
      .rdata_a  (rs_data),
      .raddr_b  (instr_q[20:16]),
      .rdata_b  (rt_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (we),
      .waddr    (dest_q),
      .wdata    (bus.alu_f)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next  = state;
      ready = 1'b0;
      we    = 1'b0;
      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.instr_valid) next = EXEC;
         end
         EXEC: next = WB;
         WB: begin
            we   = legal_q;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         dest_q  <= '0;
         legal_q <= 1'b0;
         result  <= '0;
         of_flag <= 1'b0;
         zf_flag <= 1'b0;
         illegal <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (bus.instr_valid) instr_q <= bus.instr;
            EXEC: begin
               // Unsupported words drive a zeroed AND to the ALU.
               op_q    <= dec.op;
               a_q     <= dec.legal ? rs_data : '0;
               b_q     <= !dec.legal ? '0 :
                          (dec.use_imm ? imm_ext : rt_data);
               dest_q  <= dec.dest;
               legal_q <= dec.legal;
            end
            WB: begin
               result  <= bus.alu_f;
               of_flag <= bus.alu_of;
               zf_flag <= bus.alu_zf;
               illegal <= ~legal_q;
               done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.instr_ready = ready;
   assign bus.alu_op      = op_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 3-bit-op ALU.
// Linear stimulus; immediate assertions at each comparison point.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        done, of_flag, zf_flag, illegal;
   logic [31:0] result, dbg_data;
   logic [4:0]  dbg_addr;
   logic [31:0] f_m;
   logic        of_m, zf_m;
   int          checks = 0;
   int          failures = 0;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .done     (done),
      .result   (result),
      .of_flag  (of_flag),
      .zf_flag  (zf_flag),
      .illegal  (illegal),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   always_comb begin
      f_m  = '0;
      of_m = 1'b0;
      case (bus.alu_op)
         3'b000: f_m = bus.alu_a & bus.alu_b;
         3'b001: f_m = bus.alu_a | bus.alu_b;
         3'b010: f_m = bus.alu_a ^ bus.alu_b;
         3'b011: f_m = ~(bus.alu_a ^ bus.alu_b);
         3'b100: begin
            f_m  = bus.alu_a + bus.alu_b;
            of_m = (bus.alu_a[31] == bus.alu_b[31]) &&
                   (f_m[31] != bus.alu_a[31]);
         end
         3'b101: begin
            f_m  = bus.alu_a - bus.alu_b;
            of_m = (bus.alu_a[31] != bus.alu_b[31]) &&
                   (f_m[31] != bus.alu_a[31]);
         end
         3'b110: f_m = {31'd0, bus.alu_a < bus.alu_b};
         default: f_m = bus.alu_b << bus.alu_a[4:0];
      endcase
      zf_m = (f_m == 32'd0);
   end

   assign bus.alu_f  = f_m;
   assign bus.alu_of = of_m;
   assign bus.alu_zf = zf_m;

   function automatic logic [31:0] rty(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rs,
      input logic [4:0] rt, input logic [15:0] imm);
      return {6'b001000, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] r,
                     input logic [31:0] exp);
      dbg_addr = r;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   // Called at a negedge; leaves the bench at the negedge where done is high.
   task automatic send(input string tag, input logic [31:0] w,
      input logic [4:0] dest, input logic [31:0] old_v,
      input logic [31:0] new_v);
      int n = 0;
      while (!bus.instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
      dbg_addr        = dest;
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      chk({tag, "_busy_exec"}, {31'd0, bus.instr_ready}, 32'd0);
      @(negedge clk);
      chk({tag, "_busy_wb"}, {31'd0, bus.instr_ready}, 32'd0);
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      chk({tag, "_dbg_old"}, dbg_data, old_v);
      @(negedge clk);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_dbg_new"}, dbg_data, new_v);
   endtask

   initial begin
      logic [31:0] bw [5];
      int          acc [5];
      int          idx, cyc;

      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      dbg_addr        = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {28'd0, of_flag, zf_flag, illegal}, 32'd0);
      chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_b", bus.alu_b, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      send("addi_r1", addi(0, 1, 16'h0005), 1, 0, 32'h5);
      chk("addi_r1_res", result, 32'h5);
      send("addi_r2", addi(0, 2, 16'hFFFF), 2, 0, 32'hFFFF_FFFF);
      send("add_r3", rty(1, 2, 3, 6'b100000), 3, 0, 32'h4);
      chk("add_r3_of", {31'd0, of_flag}, 32'd0);
      send("sub_r4", rty(1, 1, 4, 6'b100010), 4, 0, 32'h0);
      chk("sub_r4_zf", {31'd0, zf_flag}, 32'd1);
      send("addi_r5", addi(0, 5, 16'h7FFF), 5, 0, 32'h7FFF);
      chk("addi_r5_zf", {31'd0, zf_flag}, 32'd0);
      send("addi_r8", addi(0, 8, 16'd16), 8, 0, 32'h10);
      send("sllv_r6", rty(8, 5, 6, 6'b000100), 6, 0, 32'h7FFF_0000);
      send("sltu_r7", rty(1, 2, 7, 6'b101011), 7, 0, 32'h1);
      send("xor_r9", rty(1, 2, 9, 6'b100110), 9, 0, 32'hFFFF_FFFA);
      send("or_r10", rty(1, 5, 10, 6'b100101), 10, 0, 32'h7FFF);
      send("and_r11", rty(2, 5, 11, 6'b100100), 11, 0, 32'h7FFF);
      send("xnor_r12", rty(1, 1, 12, 6'b100111), 12, 0, 32'hFFFF_FFFF);
      send("add_ovf", rty(6, 6, 13, 6'b100000), 13, 0, 32'hFFFE_0000);
      chk("add_ovf_of", {31'd0, of_flag}, 32'd1);
      send("add_self", rty(1, 1, 1, 6'b100000), 1, 32'h5, 32'hA);
      send("add_r0", rty(1, 1, 0, 6'b100000), 0, 0, 0);
      chk("add_r0_res", result, 32'h14);
      chk("add_r0_illegal", {31'd0, illegal}, 32'd0);

      send("bad_fn", rty(1, 2, 3, 6'b001000), 3, 32'h4, 32'h4);
      chk("bad_illegal", {31'd0, illegal}, 32'd1);
      chk("bad_result", result, 32'h0);
      chk("bad_zf", {31'd0, zf_flag}, 32'd1);
      chk("bad_alu_a", bus.alu_a, 32'd0);
      chk("bad_alu_b", bus.alu_b, 32'd0);
      rd("bad_r1", 1, 32'hA);
      rd("bad_r2", 2, 32'hFFFF_FFFF);
      rd("bad_r6", 6, 32'h7FFF_0000);

      send("add_r15", rty(1, 2, 15, 6'b100000), 15, 0, 32'h9);
      chk("add_r15_illegal", {31'd0, illegal}, 32'd0);

      // Abort: reset lands while the ADD sits in EXEC.
      dbg_addr        = 3;
      bus.instr_valid = 1'b1;
      bus.instr       = rty(1, 2, 3, 6'b100000);
      @(negedge clk);
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_flags", {28'd0, of_flag, zf_flag, illegal}, 32'd0);
      chk("abort_alu_op", {29'd0, bus.alu_op}, 32'd0);
      chk("abort_alu_a", bus.alu_a, 32'd0);
      chk("abort_r3", dbg_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back: valid held high; each word must land exactly once.
      bw[0] = addi(0, 1, 16'd1);
      for (int i = 1; i < 5; i++) bw[i] = addi(1, 1, 16'd1);
      dbg_addr        = 1;
      idx             = 0;
      cyc             = 0;
      bus.instr_valid = 1'b1;
      bus.instr       = bw[0];
      while (idx < 5 && cyc < 60) begin
         if (bus.instr_ready) begin
            acc[idx] = cyc;
            idx++;
            @(negedge clk);
            cyc++;
            if (idx < 5) bus.instr = bw[idx];
            else         bus.instr_valid = 1'b0;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.instr_valid = 1'b0;
      chk("b2b_accepts", idx, 5);
      for (int i = 0; i < 4; i++)
         if (i + 1 < idx) chk("b2b_interval", acc[i+1] - acc[i], 3);
      repeat (2) @(negedge clk);
      chk("b2b_done", {31'd0, done}, 32'd1);
      rd("b2b_r1", 1, 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the team's combinational 3-bit-op ALU interface (ALU_OP/A/B in, F/OF/ZF out).
- Accepts MIPS-style instruction words over a valid/ready handshake, decodes them to an ALU op, and reads operands from an internal 32x32 register file.
- Drives the external ALU, captures F/OF/ZF, and writes the result back.
- Sits between the instruction source (bench or fetch stage) and the ALU instance.

Parameters:
- REG_W, 32, data width; must match the ALU width.
- NREG, 32, register count; r0 is hard-wired to 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  an instruction word is offered
- instr_ready  out  1  block can accept an instruction
- instr  in  32  instruction word
- alu_op  out  3  drives ALU_OP
- alu_a  out  32  drives A
- alu_b  out  32  drives B
- alu_f  in  32  ALU result F
- alu_of  in  1  ALU overflow flag
- alu_zf  in  1  ALU zero flag
- done  out  1  one-cycle pulse when an instruction retires
- result  out  32  last captured F
- of_flag  out  1  last captured OF
- zf_flag  out  1  last captured ZF
- illegal  out  1  last instruction was unsupported
- dbg_addr  in  5  debug register-file read address
- dbg_data  out  32  asynchronous read of regfile[dbg_addr]

Behaviour:
- Clocking and reset: one clock domain, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - state = IDLE, instr_ready = 1.
  - alu_op, alu_a, alu_b, result = 0.
  - done, of_flag, zf_flag, illegal = 0.
  - All registers cleared to 0.
- FSM, one state per cycle:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr and go to EXEC.
  - EXEC: instr_ready = 0. Decode the latched word, read rs/rt asynchronously, register alu_op, alu_a, alu_b, then go to WB.
  - WB: ALU outputs are stable from the registered inputs. Sample alu_f → result, alu_of → of_flag, alu_zf → zf_flag. Perform writeback, pulse done, return to IDLE.
- Latency and throughput:
  - Accept at edge N, ALU driven from edge N+1, retire at edge N+2.
  - done is high in the cycle after the N+2 edge.
  - Throughput is 1 instruction per 3 cycles.
- Decode, R-type (opcode 000000), dest = rd:
  - funct 100100 → op 000 AND
  - funct 100101 → op 001 OR
  - funct 100110 → op 010 XOR
  - funct 100111 → op 011 XNOR
  - funct 100000 → op 100 ADD
  - funct 100010 → op 101 SUB
  - funct 101011 → op 110 SLTU
  - funct 000100 → op 111 shift: A = rs, B = rt, F = rt << rs
- Decode, I-type ADDI (opcode 001000):
  - op 100, A = rs, B = sign-extended imm[15:0], dest = rt.
- Operand mapping: for R-type, A = rs and B = rt unless noted.
- Illegal instructions (any other opcode/funct):
  - alu_op = 000, alu_a = 0, alu_b = 0.
  - No writeback; illegal = 1 at retire.
  - result and flags still capture the ALU outputs.
  - Legal instructions clear illegal at retire.
- Writeback:
  - At WB, only if legal and dest != 0.
  - Writes to r0 are dropped; r0 always reads 0.
- Flags: captured verbatim from the ALU. OF is meaningful only for ADD/SUB/ADDI; no masking is applied.
- Boundaries:
  - instr_valid while busy: ignored; the source must hold it until ready.
  - rst in EXEC or WB: abort with no writeback, no done, and all outputs back to their reset values.
  - rs == rt == dest: reads use the pre-write value; the write lands at WB.
  - dbg_addr equal to the register being written: shows the old value until the WB edge.

Decomposition:
- Package alu_issue_pkg:
  - ALU op constants OP_AND through OP_SLL (000 through 111).
  - Opcode and funct constants.
  - State encoding IDLE/EXEC/WB.
- Sub-module reg_file_32x32:
  - Two asynchronous read ports plus a debug read port.
  - One synchronous write port, gated on we & (waddr != 0).
  - Synchronous clear on rst.
- The ALU itself stays external.

Test Plan:
- After rst, ADDI r1,r0,0x0005 then ADDI r2,r0,0xFFFF:
  - r1 = 0x00000005, r2 = 0xFFFFFFFF.
  - done asserted 3 cycles after each accept.
  - instr_ready = 0 for 2 cycles.
- With r1=5, r2=0xFFFFFFFF: ADD r3,r1,r2 → r3 = 0x00000004, and SUB r4,r1,r1 → r4 = 0, zf_flag = 1.
- ADDI r5,r0,0x7FFF, then SLLV r6,r5,r... with rs holding 16:
  - r6 = 0x7FFF0000.
  - SLTU r7,r1,r2 → r7 = 0x00000001.
- ADD r0,r1,r1 → r0 still reads 0 via dbg_data. Then funct 001000 (unsupported) → illegal = 1, no register changed, done pulses.
- Assert rst in the EXEC cycle of ADD r3,r1,r2 → no write to r3, all outputs 0 next cycle, instr_ready = 1.
- Hold instr_valid high with back-to-back words → exactly one accept per 3 cycles, none dropped or duplicated.
